program_loader: RTL
===================

Name: program_loader

Overview:
Writer side of the instruction memory. It receives a byte stream over a valid/ready interface and assembles little-endian 32-bit words. It writes them one per pulse into program memory, starting at the text-segment base address 0x0040_0000, and holds the processor until the image is complete. Program memory decodes a word index as (address - BASE_ADDRESS) >> 2, and this block generates addresses to match.

Parameters:
MEMORY_DEPTH, 32, number of words in program memory; maximum accepted image size
DATA_WIDTH, 32, instruction/data word width
BASE_ADDRESS, 32'h0040_0000, byte address of the first instruction word

Ports:
clk  input  1  system clock; all logic on rising edge
reset  input  1  synchronous, active-high reset
start  input  1  one-cycle pulse that begins a load
rx_data  input  8  incoming byte
rx_valid  input  1  rx_data valid
rx_ready  output  1  loader accepts a byte; a transfer occurs on an edge where rx_valid && rx_ready
mem_we  output  1  program memory write strobe, one cycle per word
mem_address  output  DATA_WIDTH  byte address of the word being written
mem_wdata  output  DATA_WIDTH  word being written
cpu_hold  output  1  processor held in reset while high
done  output  1  image loaded successfully
error  output  1  load aborted
words_loaded  output  DATA_WIDTH  count of completed word writes

Behaviour:
- Reset values, applied on the edge where reset=1 and overriding all other inputs:
  - state IDLE
  - rx_ready=0, mem_we=0, mem_wdata=0, done=0, error=0, words_loaded=0
  - mem_address=BASE_ADDRESS
  - cpu_hold=1
  - byte counter=0, word count register=0
- States: IDLE, HEADER, LOAD, WRITE, DONE, ERROR.
- IDLE:
  - rx_ready=0.
  - start=1 -> HEADER; clear words_loaded; set mem_address=BASE_ADDRESS.
- HEADER:
  - rx_ready=1.
  - Accept 4 bytes, least significant first, into word count N.
  - On the edge accepting the 4th byte:
    - N==0 -> DONE.
    - N>MEMORY_DEPTH -> ERROR.
    - Otherwise -> LOAD.
- LOAD:
  - rx_ready=1.
  - Bytes are shifted in little-endian: the first byte goes to bits [7:0] and the 4th byte to [31:24].
  - On the edge accepting the 4th byte -> WRITE.
- WRITE (exactly one cycle):
  - rx_ready=0, mem_we=1.
  - mem_wdata=assembled word.
  - mem_address=BASE_ADDRESS + 4*words_loaded, registered (modulo 2^32).
  - At the end of the cycle, words_loaded increments, mem_address advances by 4, and mem_we returns to 0.
  - If the new words_loaded==N -> DONE; otherwise -> LOAD.
- Latency: minimum 5 cycles per word (4 accepts + 1 write). rx_valid gaps stall the loader indefinitely; there is no timeout.
- DONE:
  - done=1, cpu_hold=0, rx_ready=0.
  - Holds until reset or start.
  - start -> HEADER with done=0, cpu_hold=1, words_loaded=0.
- ERROR:
  - error=1, cpu_hold=1, rx_ready=0, no further writes.
  - Left only by reset, or by start (-> HEADER, error=0).
- start is ignored in HEADER, LOAD and WRITE.
- Bytes presented while rx_ready=0 are not consumed.
- Reset mid-load: all outputs return to reset values on that edge. Words already written remain in memory and are not cleared.
- mem_we is never asserted outside WRITE.

Optional Feature:
- Macro: PROGRAM_LOADER_CHECKSUM_EN.
- Defined:
  - After the last WRITE, go to state CHECK with rx_ready=1.
  - Accept 4 trailer bytes, little-endian.
  - Compare the trailer to the modulo-2^32 sum of all written words: match -> DONE, mismatch -> ERROR.
  - N==0 also requires a trailer of 0.
  - cpu_hold stays 1 until DONE.
- Undefined: no CHECK state; WRITE of the last word goes directly to DONE, and no trailer bytes are accepted.

Test Plan:
- Load two words: reset, start, then bytes 02 00 00 00, 13 01 50 00, 93 01 A0 00 -> mem_we pulses at 0x00400000 with data 0x00500113 and at 0x00400004 with data 0x00A00193; then done=1, cpu_hold=0, words_loaded=2.
- Empty image: header 00 00 00 00 -> DONE on the next cycle, no mem_we pulse, cpu_hold=0.
- Oversize image: header 21 00 00 00 with MEMORY_DEPTH=32 -> error=1, cpu_hold=1, rx_ready=0, no mem_we; a following start returns to HEADER with error=0.
- Flow control: the first test repeated with 0-3 random idle cycles between bytes -> identical writes; no byte is consumed while rx_ready=0 (during WRITE).
- Reset mid-load: reset after the 2nd byte of word 0 -> reset values on the next edge; a new start then loads correctly from 0x00400000.
- Checksum (PROGRAM_LOADER_CHECKSUM_EN): words 0x1 and 0x2 with trailer 03 00 00 00 -> done=1; same words with trailer 04 00 00 00 -> error=1, cpu_hold=1.

Source files
------------

// File: rtl/program_loader.sv
// Byte-stream program loader: assembles little-endian words and writes them into program memory.
// Optional trailer checksum verification enabled by defining PROGRAM_LOADER_CHECKSUM_EN.
module program_loader #(
  parameter int unsigned              MEMORY_DEPTH = 32,
  parameter int unsigned              DATA_WIDTH   = 32,
  parameter logic [DATA_WIDTH-1:0]    BASE_ADDRESS = 32'h0040_0000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [7:0]            rx_data,
  input  logic                  rx_valid,
  output logic                  rx_ready,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_address,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  cpu_hold,
  output logic                  done,
  output logic                  error,
  output logic [DATA_WIDTH-1:0] words_loaded
);

  typedef enum logic [2:0] {
    StIdle,
    StHeader,
    StLoad,
    StWrite,
    StDone,
`ifdef PROGRAM_LOADER_CHECKSUM_EN
    StCheck,
`endif
    StError
  } state_e;

  state_e                state_q, state_d;
  logic [1:0]            byte_cnt_q, byte_cnt_d;
  logic [31:0]           count_q, count_d;
  logic [DATA_WIDTH-1:0] word_q, word_d;
  logic [DATA_WIDTH-1:0] loaded_q, loaded_d;
  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] sum_q, sum_d;

  // State after the last word (or an empty header): trailer check if enabled.
  state_e                fin_state;
`ifdef PROGRAM_LOADER_CHECKSUM_EN
  assign fin_state = StCheck;
`else
  assign fin_state = StDone;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      byte_cnt_q <= '0;
      count_q    <= '0;
      word_q     <= '0;
      loaded_q   <= '0;
      addr_q     <= BASE_ADDRESS;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      count_q    <= count_d;
      word_q     <= word_d;
      loaded_q   <= loaded_d;
      addr_q     <= addr_d;
      sum_q      <= sum_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    count_d    = count_q;
    word_d     = word_q;
    loaded_d   = loaded_q;
    addr_d     = addr_q;
    sum_d      = sum_q;
    rx_ready   = 1'b0;
    mem_we     = 1'b0;
    mem_wdata  = '0;
    cpu_hold   = 1'b1;
    done       = 1'b0;
    error      = 1'b0;

    unique case (state_q)
      StIdle: ;
      StHeader: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          count_d    = {rx_data, count_q[31:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            if (count_d == 32'd0)                     state_d = fin_state;
            else if (count_d > 32'(MEMORY_DEPTH))     state_d = StError;
            else                                      state_d = StLoad;
          end
        end
      end
      StLoad: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          word_d     = {rx_data, word_q[DATA_WIDTH-1:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = StWrite;
        end
      end
      StWrite: begin
        mem_we    = 1'b1;
        mem_wdata = word_q;
        loaded_d  = loaded_q + DATA_WIDTH'(1);
        addr_d    = addr_q + DATA_WIDTH'(4);
        sum_d     = sum_q + word_q;
        state_d   = (loaded_d == DATA_WIDTH'(count_q)) ? fin_state : StLoad;
      end
`ifdef PROGRAM_LOADER_CHECKSUM_EN
      StCheck: begin
        rx_ready = 1'b1;
        if (rx_valid) begin
          word_d     = {rx_data, word_q[DATA_WIDTH-1:8]};
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) state_d = (word_d == sum_q) ? StDone : StError;
        end
      end
`endif
      StDone: begin
        done     = 1'b1;
        cpu_hold = 1'b0;
      end
      StError: error = 1'b1;
      default: state_d = StIdle;
    endcase

    // A new load may only begin from a quiescent state.
    if (start && (state_q == StIdle || state_q == StDone || state_q == StError)) begin
      state_d    = StHeader;
      byte_cnt_d = '0;
      loaded_d   = '0;
      addr_d     = BASE_ADDRESS;
      sum_d      = '0;
    end
  end

  assign mem_address  = addr_q;
  assign words_loaded = loaded_q;

endmodule
